vga_sync_receiver: RTL and testbench

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

---
 rtl/vga_sync_receiver.sv | 224 ++++++++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates and line/frame timing from an incoming hs/vs/de stream,
// locking once LOCK_FRAMES consecutive frames match the configured raster.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       de_in,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       pixel_valid,
  output logic       locked,
  output logic       frame_start,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic       timing_err,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [8:0] V_ACT   = 9'(V_ACTIVE);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);
  localparam logic [9:0] CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       s1_hs, s1_vs, s1_de;
  logic       s2_hs, s2_vs;
  logic       hs_fall, vs_fall;
  logic [9:0] h_cnt, v_cnt;
  logic       h_seen, v_seen;
  logic [9:0] line_meas, frame_meas;
  logic       line_bad, len_bad, watchdog;
  logic       frame_bad, frame_bad_now, frame_good;
  logic [9:0] x_cnt, x_base, x_pix;
  logic       x_ovf;
  logic [8:0] y_cnt, y_nx;
  logic       y_full, y_full_nx, y_ovf;
  logic       line_de;
  state_t     state;
  logic [7:0] good_cnt;

  // Stage s1/s2: input capture and edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs <= 1'b1;
      s1_vs <= 1'b1;
      s1_de <= 1'b0;
      s2_hs <= 1'b1;
      s2_vs <= 1'b1;
    end else begin
      s1_hs <= hs_in;
      s1_vs <= vs_in;
      s1_de <= de_in;
      s2_hs <= s1_hs;
      s2_vs <= s1_vs;
    end
  end

  assign hs_fall    = s2_hs & ~s1_hs;
  assign vs_fall    = s2_vs & ~s1_vs;
  assign line_meas  = sat_inc10(h_cnt);
  assign frame_meas = sat_inc10(v_cnt);
  // A line ending right as h_cnt saturates is a measurement, not a watchdog trip
  assign watchdog   = (h_cnt == CNT_MAX) & ~hs_fall;
  assign line_bad   = hs_fall & h_seen & (line_meas != H_TOT);
  assign len_bad    = vs_fall & v_seen & (frame_meas != V_TOT);

  assign x_base = hs_fall ? 10'd0 : x_cnt;
  assign x_ovf  = s1_de & (x_base == H_ACT);
  assign x_pix  = x_ovf ? H_ACT - 10'd1 : x_base;

  always_comb begin
    y_nx      = y_cnt;
    y_full_nx = y_full;
    if (vs_fall) begin
      y_nx      = '0;
      y_full_nx = 1'b0;
    end else if (hs_fall && line_de) begin
      if (y_cnt == V_ACT - 9'd1) y_full_nx = 1'b1;
      else                       y_nx      = y_cnt + 9'd1;
    end
  end

  assign y_ovf         = s1_de & y_full_nx;
  assign frame_bad_now = frame_bad | line_bad | x_ovf | y_ovf;
  assign frame_good    = v_seen & (frame_meas == V_TOT) & ~frame_bad_now;

  // Period measurement and raster position tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      frame_bad   <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      y_full      <= 1'b0;
      line_de     <= 1'b0;
    end else begin
      h_cnt <= hs_fall ? 10'd0 : sat_inc10(h_cnt);
      if (hs_fall && h_seen) line_len <= line_meas;
      if (watchdog)     h_seen <= 1'b0;
      else if (hs_fall) h_seen <= 1'b1;

      if (vs_fall)      v_cnt <= '0;
      else if (hs_fall) v_cnt <= sat_inc10(v_cnt);
      if (vs_fall && v_seen) frame_lines <= frame_meas;
      if (watchdog)     v_seen <= 1'b0;
      else if (vs_fall) v_seen <= 1'b1;

      if (vs_fall)                           frame_bad <= 1'b0;
      else if (line_bad || x_ovf || y_ovf)   frame_bad <= 1'b1;

      if (x_ovf)        x_cnt <= H_ACT - 10'd1;
      else if (s1_de)   x_cnt <= x_base + 10'd1;
      else if (hs_fall) x_cnt <= '0;

      if (hs_fall)    line_de <= s1_de;
      else if (s1_de) line_de <= 1'b1;

      y_cnt  <= y_nx;
      y_full <= y_full_nx;
    end
  end

  // Lock FSM with error reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      good_cnt   <= '0;
      timing_err <= 1'b0;
      err_count  <= '0;
    end else begin
      timing_err <= 1'b0;
      if (watchdog) begin
        state    <= SEARCH;
        locked   <= 1'b0;
        good_cnt <= '0;
        if (state == LOCKED) begin
          timing_err <= 1'b1;
          err_count  <= sat_inc8(err_count);
        end
      end else begin
        if (state == LOCKED && (line_bad || len_bad)) begin
          timing_err <= 1'b1;
          err_count  <= sat_inc8(err_count);
        end
        if (vs_fall) begin
          case (state)
            SEARCH: begin
              state    <= VERIFY;
              locked   <= 1'b0;
              good_cnt <= '0;
            end
            VERIFY: begin
              if (frame_good) begin
                good_cnt <= good_cnt + 8'd1;
                if (good_cnt + 8'd1 >= LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else begin
                good_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!frame_good) begin
                state    <= VERIFY;
                locked   <= 1'b0;
                good_cnt <= '0;
              end
            end
            default: begin
              state  <= SEARCH;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Output stage: coordinates qualified by lock
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      pixel_valid <= s1_de & locked;
      frame_start <= vs_fall;
      if (s1_de && locked) begin
        x <= x_pix;
        y <= y_nx;
      end else begin
        x <= '0;
        y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver on a reduced 64x20 raster; a scoreboard
// holds expected pixel coordinates and arrival cycles.
module tb_vga_sync_receiver;

  localparam int HT  = 64;
  localparam int HSW = 8;
  localparam int HA0 = 16;
  localparam int HA  = 32;
  localparam int VT  = 20;
  localparam int VSL = 2;
  localparam int VA0 = 4;
  localparam int VA  = 10;

  logic       clk = 1'b0;
  logic       rst, hs_in, vs_in, de_in;
  logic [9:0] x;
  logic [8:0] y;
  logic       pixel_valid, locked, frame_start, timing_err;
  logic [9:0] line_len, frame_lines;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
    .x(x), .y(y), .pixel_valid(pixel_valid), .locked(locked),
    .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
    .timing_err(timing_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct { int px; int py; int cyc; } pix_t;
  pix_t sb[$];
  pix_t p;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int te_cnt = 0;
  int fs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (timing_err === 1'b1) te_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    if (pixel_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pixel", 32'(pixel_valid), 32'd0);
      end else begin
        p = sb.pop_front();
        check("pix_x", 32'(x), 32'(p.px));
        check("pix_y", 32'(y), 32'(p.py));
        check("pix_latency", 32'(cyc), 32'(p.cyc));
      end
    end
  end

  task automatic drive_cycle(input bit h, input bit v, input bit d);
    @(posedge clk);
    #1;
    hs_in = h;
    vs_in = v;
    de_in = d;
  endtask

  task automatic drive_frame(input int nlines, input int long_line, input bit exp_lock);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == long_line) ? HT + 1 : HT;
      for (int c = 0; c < len; c++) begin
        bit d;
        d = (l >= VA0) && (l < VA0 + VA) && (c >= HA0) && (c < HA0 + HA);
        drive_cycle(c >= HSW, l >= VSL, d);
        if (d && exp_lock) sb.push_back('{px: c - HA0, py: l - VA0, cyc: cyc + 2});
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_pixel_valid"}, 32'(pixel_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    check({tag, "_line_len"}, 32'(line_len), 32'd0);
    check({tag, "_frame_lines"}, 32'(frame_lines), 32'd0);
    check({tag, "_timing_err"}, 32'(timing_err), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Acquire lock: third vs_fall locks
    drive_frame(VT, -1, 1'b0);
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("f2_locked", 32'(locked), 32'd0);
    drive_frame(VT, -1, 1'b1);
    @(negedge clk);
    check("f3_locked", 32'(locked), 32'd1);
    check("f3_line_len", 32'(line_len), 32'(HT));
    check("f3_frame_lines", 32'(frame_lines), 32'(VT));
    check("f3_err_count", 32'(err_count), 32'd0);

    // One long line while locked
    drive_frame(VT, 6, 1'b1);
    @(negedge clk);
    check("long_err_count", 32'(err_count), 32'd1);
    check("long_te_pulses", 32'(te_cnt), 32'd1);
    check("long_still_locked", 32'(locked), 32'd1);
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("long_unlocked", 32'(locked), 32'd0);
    drive_frame(VT, -1, 1'b0);
    drive_frame(VT, -1, 1'b1);
    @(negedge clk);
    check("long_relocked", 32'(locked), 32'd1);
    check("long_err_final", 32'(err_count), 32'd1);

    // Short frame while locked
    drive_frame(VT - 1, -1, 1'b1);
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("short_frame_lines", 32'(frame_lines), 32'(VT - 1));
    check("short_locked", 32'(locked), 32'd0);
    check("short_err_count", 32'(err_count), 32'd2);
    check("short_te_pulses", 32'(te_cnt), 32'd2);
    drive_frame(VT, -1, 1'b0);
    drive_frame(VT, -1, 1'b1);
    @(negedge clk);
    check("short_relocked", 32'(locked), 32'd1);

    // hsync stalls: watchdog drops to SEARCH
    for (int i = 0; i < 1030; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("wd_locked", 32'(locked), 32'd0);
    check("wd_err_count", 32'(err_count), 32'd3);
    for (int i = 0; i < 70; i++) drive_cycle(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("wd_te_pulses", 32'(te_cnt), 32'd3);
    drive_frame(VT, -1, 1'b0);
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("wd_not_yet_locked", 32'(locked), 32'd0);
    drive_frame(VT, -1, 1'b1);
    @(negedge clk);
    check("wd_relocked", 32'(locked), 32'd1);
    check("wd_err_final", 32'(err_count), 32'd3);

    // Reset mid-line while locked
    drive_frame(6, -1, 1'b1);
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    check("pre_rst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("rst_f1_locked", 32'(locked), 32'd0);
    drive_frame(VT, -1, 1'b0);
    @(negedge clk);
    check("rst_f2_locked", 32'(locked), 32'd0);
    drive_frame(VT, -1, 1'b1);
    @(negedge clk);
    check("rst_f3_locked", 32'(locked), 32'd1);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_line_len", 32'(line_len), 32'(HT));
    check("rst_frame_lines", 32'(frame_lines), 32'(VT));

    check("te_pulses_total", 32'(te_cnt), 32'd3);
    check("frame_start_pulses", 32'(fs_cnt), 32'd18);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
